// File: rtl/ft60x_245fifo_device_if.sv
// rtl/ft60x_245fifo_device_if.sv - FT60x 245 synchronous FIFO bus signals
interface ft60x_245fifo_device_if #(
  parameter int FIFO_BUS_WIDTH = 2
);
  logic                          usb_txe_n;
  logic                          usb_rxf_n;
  logic                          usb_wr_n;
  logic                          usb_rd_n;
  logic                          usb_oe_n;
  logic [FIFO_BUS_WIDTH-1:0]     usb_be_i;
  logic [FIFO_BUS_WIDTH-1:0]     usb_be_o;
  logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_i;
  logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_o;
  logic                          usb_data_t;

  // master = FPGA-side driver, slave = emulated chip
  modport master (
    input  usb_txe_n, usb_rxf_n, usb_be_o, usb_data_o, usb_data_t,
    output usb_wr_n, usb_rd_n, usb_oe_n, usb_be_i, usb_data_i
  );
  modport slave (
    output usb_txe_n, usb_rxf_n, usb_be_o, usb_data_o, usb_data_t,
    input  usb_wr_n, usb_rd_n, usb_oe_n, usb_be_i, usb_data_i
  );
endinterface

// File: rtl/ft60x_245fifo_device.sv
// rtl/ft60x_245fifo_device.sv - FT600/FT601 chip-side emulation of the 245 synchronous FIFO bus
module ft60x_245fifo_device #(
  parameter int FIFO_BUS_WIDTH = 2,
  parameter int RX_DEPTH       = 64,
  parameter int TX_DEPTH       = 64
) (
  input  logic                        usb_clk,
  input  logic                        rst_usbclk,
  input  logic                        usb_rstn,
  ft60x_245fifo_device_if.slave       bus,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [FIFO_BUS_WIDTH*8-1:0] s_axis_tdata,
  input  logic [FIFO_BUS_WIDTH-1:0]   s_axis_tkeep,
  input  logic                        s_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [FIFO_BUS_WIDTH*8-1:0] m_axis_tdata,
  output logic [FIFO_BUS_WIDTH-1:0]   m_axis_tkeep,
  output logic                        m_axis_tlast
);
  localparam int BW    = FIFO_BUS_WIDTH;
  localparam int DW    = FIFO_BUS_WIDTH * 8;
  localparam int EW    = DW + BW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
  localparam logic [RX_AW:0] RX_ONE  = (RX_AW+1)'(1);
  localparam logic [TX_AW:0] TX_HIGH = (TX_AW+1)'(TX_DEPTH - 2);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_AVAIL = 2'd1;
  localparam logic [1:0] RX_GAP   = 2'd2;

  logic rst;
  assign rst = rst_usbclk | ~usb_rstn;

  logic [EW-1:0]    rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_AW:0]   rx_count, rx_count_next;
  logic [1:0]       rx_state;
  logic [EW-1:0]    rx_head;
  logic             rx_push, rx_pop, rx_nonempty;
  logic             bus_t;

  assign rx_head     = rx_mem[rx_rd_ptr];
  assign rx_nonempty = (rx_count != '0);
  assign rx_push     = s_axis_tvalid & s_axis_tready;
  assign rx_pop      = (rx_state == RX_AVAIL) & ~bus.usb_oe_n & ~bus.usb_rd_n;

  always_comb begin
    rx_count_next = rx_count;
    if (rx_push && !rx_pop)
      rx_count_next = rx_count + 1'b1;
    else if (!rx_push && rx_pop)
      rx_count_next = rx_count - 1'b1;
  end

  always_ff @(posedge usb_clk) begin
    if (rx_push)
      rx_mem[rx_wr_ptr] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  end

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      rx_count      <= '0;
      rx_state      <= RX_IDLE;
      s_axis_tready <= 1'b0;
      bus_t         <= 1'b1;
    end else begin
      if (rx_push)
        rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)
        rx_rd_ptr <= rx_rd_ptr + 1'b1;
      rx_count      <= rx_count_next;
      s_axis_tready <= (rx_count_next < RX_FULL);
      // one turnaround cycle between oe_n falling and the device driving
      bus_t         <= bus.usb_oe_n;
      case (rx_state)
        RX_IDLE:  if (rx_nonempty) rx_state <= RX_AVAIL;
        RX_AVAIL: if (rx_pop && (rx_head[0] || rx_count == RX_ONE)) rx_state <= RX_GAP;
        default:  rx_state <= rx_nonempty ? RX_AVAIL : RX_IDLE;
      endcase
    end
  end

  assign bus.usb_rxf_n  = (rx_state != RX_AVAIL);
  assign bus.usb_data_t = bus_t;
  assign bus.usb_data_o = (!bus_t && rx_nonempty) ? rx_head[EW-1 -: DW] : '0;
  assign bus.usb_be_o   = (!bus_t && rx_nonempty) ? rx_head[BW:1] : '0;

  logic [EW-1:0]    tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_AW:0]   tx_count, tx_count_next;
  logic [EW-1:0]    tx_head;
  logic             skid_valid;
  logic [DW-1:0]    skid_data;
  logic [BW-1:0]    skid_be;
  logic             txe_n, tx_accept, tx_pop;

  // writes are dropped whenever the device owns or is about to own the bus
  assign tx_accept = ~bus.usb_wr_n & ~txe_n & bus_t & bus.usb_oe_n;
  assign tx_pop    = m_axis_tvalid & m_axis_tready;

  always_comb begin
    tx_count_next = tx_count;
    if (skid_valid && !tx_pop)
      tx_count_next = tx_count + 1'b1;
    else if (!skid_valid && tx_pop)
      tx_count_next = tx_count - 1'b1;
  end

  // the skid word closes the burst unless another write lands on the same edge
  always_ff @(posedge usb_clk) begin
    if (skid_valid)
      tx_mem[tx_wr_ptr] <= {skid_data, skid_be, ~tx_accept};
  end

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_count   <= '0;
      skid_valid <= 1'b0;
      txe_n      <= 1'b1;
    end else begin
      if (skid_valid)
        tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)
        tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count   <= tx_count_next;
      skid_valid <= tx_accept;
      if (tx_accept) begin
        skid_data <= bus.usb_data_i;
        skid_be   <= bus.usb_be_i;
      end
      txe_n <= (tx_count_next > TX_HIGH);
    end
  end

  assign bus.usb_txe_n = txe_n;
  assign tx_head       = tx_mem[tx_rd_ptr];
  assign m_axis_tvalid = (tx_count != '0);
  assign m_axis_tdata  = tx_head[EW-1 -: DW];
  assign m_axis_tkeep  = tx_head[BW:1];
  assign m_axis_tlast  = m_axis_tvalid & tx_head[0];
endmodule

// File: doc/ft60x_245fifo_device.md
Name: ft60x_245fifo_device

Overview:
- Synthesizable emulation of the FT600/FT601 chip side of the 245 synchronous FIFO bus.
- Used as the bus partner of the FPGA-side FT60x driver in simulation and in on-board loopback builds.
- Host-to-FPGA data enters on an AXI4-Stream slave, is buffered, and is served on the FIFO bus under rxf_n/oe_n/rd_n.
- FPGA-to-host writes under txe_n/wr_n are buffered and emitted on an AXI4-Stream master, framed by write bursts.

Parameters:
- FIFO_BUS_WIDTH, 2, bus width in bytes (2 = FT600, 4 = FT601).
- RX_DEPTH, 64, host-to-FPGA buffer depth in words; power of 2, at least 4.
- TX_DEPTH, 64, FPGA-to-host buffer depth in words; power of 2, at least 4.

Ports:
- usb_clk  in  1  bus clock; the only clock.
- rst_usbclk  in  1  synchronous active-high reset.
- usb_rstn  in  1  chip reset from FPGA, active low; sampled synchronously, same effect as rst_usbclk.
- usb_txe_n  out  1  low = TX buffer can accept writes.
- usb_rxf_n  out  1  low = RX data available.
- usb_wr_n  in  1  write strobe, active low.
- usb_rd_n  in  1  read strobe, active low.
- usb_oe_n  in  1  output enable, active low.
- usb_be_i  in  FIFO_BUS_WIDTH  byte enables driven by FPGA.
- usb_be_o  out  FIFO_BUS_WIDTH  byte enables driven by device.
- usb_data_i  in  FIFO_BUS_WIDTH*8  write data from FPGA.
- usb_data_o  out  FIFO_BUS_WIDTH*8  read data to FPGA.
- usb_data_t  out  1  bus direction: 0 = device drives data/be, 1 = device tristates.
- s_axis_tvalid/tready/tdata/tkeep/tlast  in/out/in/in/in  1/1/FIFO_BUS_WIDTH*8/FIFO_BUS_WIDTH/1  host-to-FPGA stream.
- m_axis_tvalid/tready/tdata/tkeep/tlast  out/in/out/out/out  1/1/FIFO_BUS_WIDTH*8/FIFO_BUS_WIDTH/1  FPGA-to-host stream.

Behaviour:
- Reset (rst_usbclk=1 or usb_rstn=0 at a rising edge):
  - both buffers and the TX skid register are flushed; states go to IDLE.
  - Outputs: usb_txe_n=1, usb_rxf_n=1, usb_data_t=1, usb_data_o=0, usb_be_o=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
  - Reset mid-burst discards partial data; no tlast is emitted for it.
- RX buffer:
  - FWFT; stores {tdata,tkeep,tlast}.
  - s_axis_tready = registered (count < RX_DEPTH); a push occurs on tvalid & tready.
  - tkeep is stored verbatim; tkeep=0 is legal and is served as be=0.
- RX FSM, states IDLE, AVAIL, GAP:
  - IDLE -> AVAIL when count>0. In AVAIL, usb_rxf_n=0.
  - A pop occurs at a rising edge with rxf_n=0, oe_n=0 and rd_n=0. usb_data_o/usb_be_o then present the next head in the following cycle (zero-wait streaming).
  - Popping a word with tlast=1, or the last word: usb_rxf_n goes 1 the next cycle and the FSM enters GAP. GAP lasts exactly 1 cycle, then the FSM returns to IDLE/AVAIL.
  - rd_n=0 while rxf_n=1 is ignored: no pop, no error.
  - usb_data_t = registered oe_n, giving one turnaround cycle: oe_n low at edge N means the device drives from cycle N+1.
  - Data shown while driving is the head word. With oe_n low and rd_n high, the head holds, so no data is lost.
  - Push and pop in the same cycle are allowed; count is unchanged.
- TX path:
  - usb_txe_n = registered (free space < 2). The 2-word margin covers the skid word plus one in-flight write after txe_n rises.
  - A write is accepted at an edge with wr_n=0 and txe_n=0, and only while usb_data_t=1. A write attempted while the device drives the bus is dropped.
  - The accepted {data_i,be_i} goes to the skid register.
  - At the next edge the skid word is pushed to the TX buffer: tlast=0 if another write is accepted at that edge, tlast=1 if wr_n=1 or txe_n=1.
  - Burst end is therefore detected 1 cycle after the last write.
  - wr_n=0 while txe_n=1 is ignored and closes the current burst (tlast=1 on the skid word).
- m_axis:
  - FWFT from the TX buffer; m_axis_tvalid = count>0. A pop occurs on tvalid & tready.
  - tdata/tkeep/tlast must be held stable while tvalid=1 and tready=0.
- Simultaneous events:
  - oe_n=0 and wr_n=0 together: the write is dropped and the read proceeds.
  - Counts use log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

Test Plan:
- Reset values: reset for 3 cycles -> all outputs at the reset values above. Push 1 word on s_axis -> usb_rxf_n=0 two cycles later.
- RX burst (FIFO_BUS_WIDTH=2): push 0x0001..0x0004, tlast on 0x0004, tkeep=2'b11. FPGA holds oe_n=0, then rd_n=0 for 4 cycles -> FPGA samples 0x0001..0x0004 in order; rxf_n=1 for exactly 1 GAP cycle, then stays 1 (empty).
- Packet gap: push 3 words with tlast on word 2, then 1 more word. Continuous rd_n=0 -> rxf_n=1 for 1 cycle after word 2; word 3 is served afterwards.
- TX burst: wr_n=0 for 5 cycles with data 0xA000..0xA004 and be=2'b11, last be=2'b01 -> m_axis delivers 5 beats; tlast only on 0xA004 with tkeep=2'b01.
- TX backpressure (TX_DEPTH=8): m_axis_tready=0 while writing continuously -> txe_n rises at free space <2; no word lost or duplicated. Release tready -> all 8 words drain in order.
- usb_rstn pulse mid-RX-burst (after 2 of 4 words read) -> rxf_n=1, data_t=1 the next cycle; the buffer is empty afterwards and the subsequent stream starts fresh.
